// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select arbiter.
// Contents: FSM state enum, select codes for the three mux inputs, and
// helpers mapping an owner index (0..2) to its select code / grant bit.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A00 = 2'b00;
    localparam logic [1:0] SEL_A01 = 2'b01;
    localparam logic [1:0] SEL_A1X = 2'b10;

    function automatic logic [1:0] owner_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    owner_sel = SEL_A00;
            2'd1:    owner_sel = SEL_A01;
            default: owner_sel = SEL_A1X;
        endcase
    endfunction

    function automatic logic [2:0] owner_gnt(input logic [1:0] idx);
        case (idx)
            2'd0:    owner_gnt = 3'b001;
            2'd1:    owner_gnt = 3'b010;
            default: owner_gnt = 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational round-robin pick over three requesters.
// Ports:
//   req    [2:0] in  : request lines
//   last   [1:0] in  : most recent owner; search order is last+1, last+2, last
//   winner [1:0] out : selected requester (only meaningful when any = 1)
//   any          out : at least one request is high
module mux_rr_pick
    import mux_sel_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] c0, c1, c2;

    always_comb begin
        // c0 is the previous owner itself, tried last; code 3 is treated as 2
        c0 = 2'd2;
        c1 = 2'd0;
        c2 = 2'd1;
        case (last)
            2'd0: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
            2'd1: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            default: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
        endcase
    end

    always_comb begin
        any    = |req;
        winner = c0;
        if (req[c1])
            winner = c1;
        else if (req[c2])
            winner = c2;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the three-input mux.
// One owner at a time, bursts capped at BURST_MAX cycles when contended,
// one-cycle guard gap between owners with sel held steady.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req  [2:0]  : request lines (0 = a00, 1 = a01, 2 = a1X)
//   gnt  [2:0]  : registered one-hot grant or zero
//   sel  [1:0]  : registered mux select, changes only on entry to GRANT
//   busy        : registered, high in GRANT or GAP
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic             any;
    logic [2:0]       others;
    logic             cnt_end;
    logic             own_req;

    mux_rr_pick u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // last is loaded with the winner on grant entry, so it is also the owner
    assign others  = req & ~owner_gnt(last);
    assign own_req = |(req & owner_gnt(last));
    assign cnt_end = (cnt == CNT_W'(BURST_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 3'b000;
            sel   <= SEL_A00;
            busy  <= 1'b0;
            cnt   <= '0;
            last  <= 2'd2;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (any) begin
                        state <= GRANT;
                        gnt   <= owner_gnt(winner);
                        sel   <= owner_sel(winner);
                        last  <= winner;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        gnt   <= 3'b000;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // release wins over preemption; both go to the gap
                    if (!own_req || (cnt_end && |others)) begin
                        state <= GAP;
                        gnt   <= 3'b000;
                        busy  <= 1'b1;
                    end else begin
                        // uncontended owner keeps the channel; counter wraps
                        cnt <= cnt_end ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
